// File: rtl/pipelined_cpu.sv
// pipelined_cpu -- five-stage in-order RV32 subset core (IF, ID, EX, MEM, WB).
//
// Ports:
//   clk_i   in  1  clock, all state updates on the rising edge
//   rst_i   in  1  synchronous active-high reset (PC and pipeline registers only)
//   start_i in  1  run enable; PC and pipeline registers hold while low
//
// Supported: add, sub, and, or, mul, addi, lw, sw, beq. Every other encoding
// is a NOP. EX operands are forwarded from EX/MEM and MEM/WB, a load-use
// hazard stalls for one cycle, and beq is resolved in ID with a one-cycle
// flush. Instruction memory, data memory and register file are internal and
// are reached by name through the instance hierarchy.

package pipelined_cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;     // 1: second ALU operand is the immediate
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } idex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic [31:0] alu;
    logic [31:0] store;
    logic [4:0]  rd;
  } exmem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  rd;
  } memwb_t;

  // All-zero control is a NOP; unknown encodings fall through to it.
  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    case (instr[6:0])
      OP_R: begin
        c.reg_write = 1'b1;
        case ({instr[31:25], instr[14:12]})
          10'b0000000_000: c.alu_op = ALU_ADD;
          10'b0100000_000: c.alu_op = ALU_SUB;
          10'b0000000_111: c.alu_op = ALU_AND;
          10'b0000000_110: c.alu_op = ALU_OR;
          10'b0000001_000: c.alu_op = ALU_MUL;
          default:         c.reg_write = 1'b0;
        endcase
      end
      OP_IMM: if (instr[14:12] == 3'b000) begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_LOAD: if (instr[14:12] == 3'b010) begin
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
      end
      OP_STORE: if (instr[14:12] == 3'b010) begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// Program counter: loads the branch target or steps by 4 when enabled.
module cpu_pc (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        ld_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of the order the blocks evaluate in.
  always_ff @(posedge clk_i) begin
    if (rst_i)     pc_o <= '0;
    else if (en_i) pc_o <= ld_i ? target_i : pc_o + 32'd4;
  end
endmodule

// 256 x 32 instruction memory, combinational read. The write port is for an
// external loader; inside this core it is tied off.
module cpu_imem (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [7:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  raddr_i,
  output logic [31:0] rdata_o
);
  logic [31:0] memory [0:255];

  // NOTE: memory arrays are deliberately not reset; clearing them would need
  // a per-entry reset network and program contents must survive rst_i anyway.
  always_ff @(posedge clk_i) begin
    if (we_i) memory[waddr_i] <= wdata_i;
  end

  assign rdata_o = memory[raddr_i];
endmodule

// 32 x 32 register file, x0 hard-wired to zero, write-through to both reads.
module cpu_regfile (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] register [0:31];

  always_ff @(posedge clk_i) begin
    if (we_i && waddr_i != 5'd0) register[waddr_i] <= wdata_i;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    if (raddr1_i != 5'd0)
      rdata1_o = (we_i && waddr_i == raddr1_i) ? wdata_i : register[raddr1_i];
    if (raddr2_i != 5'd0)
      rdata2_o = (we_i && waddr_i == raddr2_i) ? wdata_i : register[raddr2_i];
  end
endmodule

// 32-byte data memory, little-endian word access, addresses wrap mod 32.
module cpu_dmem (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  logic [7:0] memory [0:31];
  logic [4:0] w_a1, w_a2, w_a3;

  assign w_a1 = addr_i + 5'd1;
  assign w_a2 = addr_i + 5'd2;
  assign w_a3 = addr_i + 5'd3;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      memory[addr_i] <= wdata_i[7:0];
      memory[w_a1]   <= wdata_i[15:8];
      memory[w_a2]   <= wdata_i[23:16];
      memory[w_a3]   <= wdata_i[31:24];
    end
  end

  assign rdata_o = {memory[w_a3], memory[w_a2], memory[w_a1], memory[addr_i]};
endmodule

// Load-use detection: a load in EX feeding either source field of ID.
module cpu_hazard (
  input  logic       idex_mem_read_i,
  input  logic [4:0] idex_rd_i,
  input  logic [4:0] ifid_rs1_i,
  input  logic [4:0] ifid_rs2_i,
  output logic       stall_o
);
  assign stall_o = idex_mem_read_i && idex_rd_i != 5'd0 &&
                   (idex_rd_i == ifid_rs1_i || idex_rd_i == ifid_rs2_i);
endmodule

// Taken-branch flush; a concurrent stall wins and the branch is retried.
module cpu_flush (
  input  logic branch_taken_i,
  input  logic stall_i,
  output logic If_flush_o
);
  assign If_flush_o = branch_taken_i && !stall_i;
endmodule

module pipelined_cpu
  import pipelined_cpu_pkg::*;
(
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);

  ifid_t  r_ifid;
  idex_t  r_idex;
  exmem_t r_exmem;
  memwb_t r_memwb;

  logic [31:0] w_pc, w_if_instr;
  logic        w_stall, w_flush, w_br_taken;
  logic [31:0] w_br_target;

  // ---------------- IF ----------------
  cpu_pc PC (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (start_i && !w_stall),
    .ld_i     (w_br_taken),
    .target_i (w_br_target),
    .pc_o     (w_pc)
  );

  cpu_imem Instruction_Memory (
    .clk_i   (clk_i),
    .we_i    (1'b0),
    .waddr_i (8'd0),
    .wdata_i (32'd0),
    .raddr_i (w_pc[9:2]),
    .rdata_o (w_if_instr)
  );

  // ---------------- ID ----------------
  logic [4:0]  w_id_rs1, w_id_rs2;
  logic [31:0] w_id_rd1, w_id_rd2, w_id_imm;
  ctrl_t       w_id_ctrl;
  logic        w_id_is_beq;
  logic        w_wb_we;
  logic [31:0] w_wb_data;

  assign w_id_rs1    = r_ifid.instr[19:15];
  assign w_id_rs2    = r_ifid.instr[24:20];
  assign w_id_ctrl   = decode(r_ifid.instr);
  assign w_id_is_beq = r_ifid.instr[6:0] == OP_BRANCH && r_ifid.instr[14:12] == 3'b000;

  always_comb begin
    w_id_imm = {{20{r_ifid.instr[31]}}, r_ifid.instr[31:20]};
    case (r_ifid.instr[6:0])
      OP_STORE:  w_id_imm = {{20{r_ifid.instr[31]}}, r_ifid.instr[31:25], r_ifid.instr[11:7]};
      // B-immediate holds offset bits [12:1]; the shift is applied at the adder.
      OP_BRANCH: w_id_imm = {{20{r_ifid.instr[31]}}, r_ifid.instr[31], r_ifid.instr[7],
                             r_ifid.instr[30:25], r_ifid.instr[11:8]};
      default: ;
    endcase
  end

  cpu_regfile Registers (
    .clk_i    (clk_i),
    .we_i     (w_wb_we),
    .waddr_i  (r_memwb.rd),
    .wdata_i  (w_wb_data),
    .raddr1_i (w_id_rs1),
    .raddr2_i (w_id_rs2),
    .rdata1_o (w_id_rd1),
    .rdata2_o (w_id_rd2)
  );

  // Branch compares raw register-file data; producers must be 3+ ahead.
  assign w_br_taken  = w_id_is_beq && (w_id_rd1 == w_id_rd2);
  assign w_br_target = r_ifid.pc + {w_id_imm[30:0], 1'b0};

  cpu_hazard HazzardDetectUnit (
    .idex_mem_read_i (r_idex.ctrl.mem_read),
    .idex_rd_i       (r_idex.rd),
    .ifid_rs1_i      (w_id_rs1),
    .ifid_rs2_i      (w_id_rs2),
    .stall_o         (w_stall)
  );

  cpu_flush Flush_Unit (
    .branch_taken_i (w_br_taken),
    .stall_i        (w_stall),
    .If_flush_o     (w_flush)
  );

  // ---------------- EX ----------------
  logic [31:0] w_ex_a, w_ex_rs2_val, w_ex_b, w_ex_alu;

  // EX/MEM wins over MEM/WB so the youngest producer is used.
  always_comb begin
    w_ex_a = r_idex.rd1;
    if (r_exmem.reg_write && r_exmem.rd != 5'd0 && r_exmem.rd == r_idex.rs1)
      w_ex_a = r_exmem.alu;
    else if (r_memwb.reg_write && r_memwb.rd != 5'd0 && r_memwb.rd == r_idex.rs1)
      w_ex_a = w_wb_data;

    w_ex_rs2_val = r_idex.rd2;
    if (r_exmem.reg_write && r_exmem.rd != 5'd0 && r_exmem.rd == r_idex.rs2)
      w_ex_rs2_val = r_exmem.alu;
    else if (r_memwb.reg_write && r_memwb.rd != 5'd0 && r_memwb.rd == r_idex.rs2)
      w_ex_rs2_val = w_wb_data;

    w_ex_b = r_idex.ctrl.alu_src ? r_idex.imm : w_ex_rs2_val;

    case (r_idex.ctrl.alu_op)
      ALU_SUB: w_ex_alu = w_ex_a - w_ex_b;
      ALU_AND: w_ex_alu = w_ex_a & w_ex_b;
      ALU_OR:  w_ex_alu = w_ex_a | w_ex_b;
      ALU_MUL: w_ex_alu = w_ex_a * w_ex_b;
      default: w_ex_alu = w_ex_a + w_ex_b;
    endcase
  end

  // ---------------- MEM ----------------
  logic [31:0] w_mem_rdata;

  cpu_dmem Data_Memory (
    .clk_i   (clk_i),
    .we_i    (r_exmem.mem_write && start_i && !rst_i),
    .addr_i  (r_exmem.alu[4:0]),
    .wdata_i (r_exmem.store),
    .rdata_o (w_mem_rdata)
  );

  // ---------------- WB ----------------
  assign w_wb_we   = r_memwb.reg_write && start_i && !rst_i;
  assign w_wb_data = r_memwb.mem_to_reg ? r_memwb.mem : r_memwb.alu;

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ifid  <= '0;
      r_idex  <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
    end else if (start_i) begin
      // IF/ID holds on a stall; a taken branch replaces it with a NOP.
      if (!w_stall) begin
        if (w_flush) begin
          r_ifid <= '0;
        end else begin
          r_ifid.pc    <= w_pc;
          r_ifid.instr <= w_if_instr;
        end
      end

      if (w_stall) begin
        r_idex <= '0;
      end else begin
        r_idex.ctrl <= w_id_ctrl;
        r_idex.rd1  <= w_id_rd1;
        r_idex.rd2  <= w_id_rd2;
        r_idex.imm  <= w_id_imm;
        r_idex.rs1  <= w_id_rs1;
        r_idex.rs2  <= w_id_rs2;
        r_idex.rd   <= r_ifid.instr[11:7];
      end

      r_exmem.reg_write  <= r_idex.ctrl.reg_write;
      r_exmem.mem_write  <= r_idex.ctrl.mem_write;
      r_exmem.mem_to_reg <= r_idex.ctrl.mem_to_reg;
      r_exmem.alu        <= w_ex_alu;
      r_exmem.store      <= w_ex_rs2_val;
      r_exmem.rd         <= r_idex.rd;

      r_memwb.reg_write  <= r_exmem.reg_write;
      r_memwb.mem_to_reg <= r_exmem.mem_to_reg;
      r_memwb.alu        <= r_exmem.alu;
      r_memwb.mem        <= w_mem_rdata;
      r_memwb.rd         <= r_exmem.rd;
    end
  end

endmodule

// File: tb/tb_pipelined_cpu.sv
// tb_pipelined_cpu -- directed bench for pipelined_cpu. Programs and data are
// preloaded through the instance hierarchy; architectural state is inspected
// 1 ns after rising edges, stall/flush events are counted at falling edges.

module tb_pipelined_cpu;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_stall  = 0;
  int n_flush  = 0;

  pipelined_cpu dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: count events of the current cycle, then cross the edge.
  task automatic step();
    @(negedge clk);
    if (start && !rst) begin
      if (dut.HazzardDetectUnit.stall_o) n_stall++;
      if (dut.Flush_Unit.If_flush_o)     n_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_all();
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'h0;
    for (int i = 0; i < 32; i++)  dut.Registers.register[i] = 32'h0;
    for (int i = 0; i < 32; i++)  dut.Data_Memory.memory[i] = 8'h0;
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    start = 1'b1;
    step();
    step();
    n_stall = 0;
    n_flush = 0;
  endtask

  task automatic prog(input int idx, input logic [31:0] w);
    dut.Instruction_Memory.memory[idx] = w;
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'b1100011};
  endfunction

  initial begin
    // ---- reset, start-up timing, forwarding, ALU ops ----
    clear_all();
    prog(0, addi(5'd1, 5'd0, 12'd5));
    prog(1, rtype(7'b0000000, 3'b000, 5'd2, 5'd1, 5'd1));   // add x2,x1,x1
    prog(2, rtype(7'b0100000, 3'b000, 5'd3, 5'd2, 5'd1));   // sub x3,x2,x1
    prog(3, rtype(7'b0000001, 3'b000, 5'd4, 5'd2, 5'd3));   // mul x4,x2,x3
    prog(4, rtype(7'b0000000, 3'b111, 5'd5, 5'd2, 5'd4));   // and x5,x2,x4
    prog(5, rtype(7'b0000000, 3'b110, 5'd6, 5'd2, 5'd3));   // or  x6,x2,x3
    prog(6, addi(5'd7, 5'd0, 12'hFFD));                     // addi x7,x0,-3
    apply_reset();
    check("reset_pc", dut.PC.pc_o, 32'd0);
    check("reset_stall", {31'd0, dut.HazzardDetectUnit.stall_o}, 32'd0);
    check("reset_flush", {31'd0, dut.Flush_Unit.If_flush_o}, 32'd0);
    rst = 1'b0;
    step(); check("pc_e1", dut.PC.pc_o, 32'd4);
    step(); check("pc_e2", dut.PC.pc_o, 32'd8);
    step(); check("pc_e3", dut.PC.pc_o, 32'd12);
    step(); check("pc_e4", dut.PC.pc_o, 32'd16);
    check("x1_e4", dut.Registers.register[1], 32'd0);
    step(); check("x1_e5", dut.Registers.register[1], 32'd5);
    steps(10);
    check("fwd_x2", dut.Registers.register[2], 32'd10);
    check("fwd_x3", dut.Registers.register[3], 32'd5);
    check("mul_x4", dut.Registers.register[4], 32'd50);
    check("and_x5", dut.Registers.register[5], 32'd2);
    check("or_x6",  dut.Registers.register[6], 32'd15);
    check("neg_x7", dut.Registers.register[7], 32'hFFFF_FFFD);
    check("fwd_stalls", n_stall, 0);

    // ---- load-use ----
    clear_all();
    dut.Data_Memory.memory[0] = 8'd5;
    prog(0, lw(5'd1, 5'd0, 12'd0));
    prog(1, rtype(7'b0000000, 3'b000, 5'd2, 5'd1, 5'd1));   // add x2,x1,x1
    apply_reset();
    rst = 1'b0;
    steps(12);
    check("lu_stalls", n_stall, 1);
    check("lu_x1", dut.Registers.register[1], 32'd5);
    check("lu_x2", dut.Registers.register[2], 32'd10);
    check("lu_pc", dut.PC.pc_o, 32'd44);

    // ---- store then load ----
    clear_all();
    for (int i = 4; i < 8; i++) dut.Data_Memory.memory[i] = 8'hAA;
    prog(0, addi(5'd1, 5'd0, 12'd7));
    prog(1, sw(5'd1, 5'd0, 12'd4));
    prog(2, lw(5'd2, 5'd0, 12'd4));
    apply_reset();
    rst = 1'b0;
    steps(12);
    check("st_b4", {24'd0, dut.Data_Memory.memory[4]}, 32'h07);
    check("st_b5", {24'd0, dut.Data_Memory.memory[5]}, 32'h00);
    check("st_b6", {24'd0, dut.Data_Memory.memory[6]}, 32'h00);
    check("st_b7", {24'd0, dut.Data_Memory.memory[7]}, 32'h00);
    check("ld_x2", dut.Registers.register[2], 32'd7);
    check("st_stalls", n_stall, 0);

    // ---- taken and not-taken beq ----
    clear_all();
    prog(0, addi(5'd1, 5'd0, 12'd1));
    prog(4, beq(5'd1, 5'd1, 13'd8));
    prog(5, addi(5'd5, 5'd0, 12'd9));
    prog(6, addi(5'd6, 5'd0, 12'd3));
    prog(7, beq(5'd1, 5'd0, 13'd8));
    prog(8, addi(5'd7, 5'd0, 12'd4));
    apply_reset();
    rst = 1'b0;
    steps(16);
    check("br_flushes", n_flush, 1);
    check("br_x5", dut.Registers.register[5], 32'd0);
    check("br_x6", dut.Registers.register[6], 32'd3);
    check("br_x7", dut.Registers.register[7], 32'd4);
    check("br_pc", dut.PC.pc_o, 32'd64);

    // ---- Fibonacci loop, n = 5, with a start_i pause ----
    clear_all();
    dut.Data_Memory.memory[0] = 8'd5;
    for (int i = 8; i < 12; i++) dut.Data_Memory.memory[i] = 8'hCC;
    prog(0,  lw(5'd1, 5'd0, 12'd0));
    prog(1,  addi(5'd2, 5'd0, 12'd0));
    prog(2,  addi(5'd3, 5'd0, 12'd1));
    prog(3,  addi(5'd4, 5'd0, 12'd0));
    prog(4,  rtype(7'b0000000, 3'b000, 5'd5, 5'd2, 5'd3));  // add x5,x2,x3
    prog(5,  addi(5'd2, 5'd3, 12'd0));
    prog(6,  addi(5'd3, 5'd5, 12'd0));
    prog(7,  addi(5'd4, 5'd4, 12'd1));
    prog(11, beq(5'd4, 5'd1, 13'd12));                      // 44 -> 56 when done
    prog(12, beq(5'd0, 5'd0, 13'h1FE0));                    // 48 -> 16
    prog(14, sw(5'd3, 5'd0, 12'd8));
    apply_reset();
    rst = 1'b0;
    steps(25);
    check("fib_pc_25", dut.PC.pc_o, 32'd20);
    start = 1'b0;
    steps(5);
    check("fib_pc_frozen", dut.PC.pc_o, 32'd20);
    start = 1'b1;
    steps(45);
    check("fib_x2", dut.Registers.register[2], 32'd5);
    check("fib_x3", dut.Registers.register[3], 32'd8);
    check("fib_x4", dut.Registers.register[4], 32'd5);
    check("fib_x5", dut.Registers.register[5], 32'd8);
    check("fib_m8",  {24'd0, dut.Data_Memory.memory[8]},  32'h08);
    check("fib_m9",  {24'd0, dut.Data_Memory.memory[9]},  32'h00);
    check("fib_m11", {24'd0, dut.Data_Memory.memory[11]}, 32'h00);
    check("fib_flushes", n_flush, 5);
    check("fib_stalls", n_stall, 0);
    check("fib_pc_end", dut.PC.pc_o, 32'd124);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
